// File: rtl/weigh_scan_controller.sv
// Weighing transaction sequencer: settle detection, camera scan with retries, serial cost divide.
// Optional running total of accepted costs when TOTAL_CNT_EN is defined.
module weigh_scan_controller #(
    parameter int unsigned MIN_WEIGHT      = 5,
    parameter int unsigned STABLE_SAMPLES  = 4,
    parameter int unsigned WEIGHT_TOL      = 2,
    parameter int unsigned SCAN_TIMEOUT    = 1000,
    parameter int unsigned SCAN_RETRIES    = 2,
    parameter int unsigned PRICE_BANANA    = 120,
    parameter int unsigned PRICE_MARACUJA  = 450,
    parameter int unsigned PRICE_TANGERINA = 230
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] weight_g,
    input  logic        weight_valid,
    output logic        cam_trigger,
    input  logic [2:0]  cam_product,
    input  logic        cam_valid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  item_id,
    output logic [15:0] item_weight,
    output logic [23:0] item_cost,
    output logic        busy,
    output logic        err
`ifdef TOTAL_CNT_EN
    ,
    input  logic        total_clr,
    output logic [31:0] total_cents
`endif
);

    typedef enum logic [2:0] {
        StIdle, StSettle, StScan, StCalc, StPresent, StWaitClear, StError
    } state_e;

    state_e      state_q;
    logic [15:0] ref_q;
    logic [7:0]  stable_cnt_q;
    logic [15:0] timer_q;
    logic [7:0]  retry_q;
    logic [31:0] div_q;
    logic [9:0]  rem_q;
    logic [5:0]  iter_q;
    logic        cam_trigger_q, out_valid_q, busy_q, err_q;
    logic [2:0]  item_id_q;
    logic [15:0] item_weight_q;
    logic [23:0] item_cost_q;

    logic        weight_low, weight_near, id_ok, timeout, quo_bit;
    logic [15:0] weight_diff;
    logic [9:0]  price;
    logic [10:0] rem_shift;
    logic [9:0]  rem_d;

    always_comb begin
        weight_low  = weight_valid && (weight_g < 16'(MIN_WEIGHT));
        weight_diff = (weight_g >= ref_q) ? (weight_g - ref_q) : (ref_q - weight_g);
        weight_near = (weight_diff <= 16'(WEIGHT_TOL));
        id_ok       = (cam_product == 3'b001) || (cam_product == 3'b010) ||
                      (cam_product == 3'b100);
        timeout     = (timer_q == 16'(SCAN_TIMEOUT - 1));
        case (cam_product)
            3'b001:  price = 10'(PRICE_BANANA);
            3'b010:  price = 10'(PRICE_MARACUJA);
            3'b100:  price = 10'(PRICE_TANGERINA);
            default: price = 10'd0;
        endcase
        // Restoring divide by 1000: dividend shifts out of div_q MSB, quotient shifts in at LSB
        rem_shift = {rem_q, div_q[31]};
        quo_bit   = (rem_shift >= 11'd1000);
        rem_d     = quo_bit ? 10'(rem_shift - 11'd1000) : rem_shift[9:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ref_q         <= '0;
            stable_cnt_q  <= '0;
            timer_q       <= '0;
            retry_q       <= '0;
            div_q         <= '0;
            rem_q         <= '0;
            iter_q        <= '0;
            cam_trigger_q <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            item_id_q     <= '0;
            item_weight_q <= '0;
            item_cost_q   <= '0;
        end else begin
            cam_trigger_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (weight_valid && !weight_low) begin
                        ref_q        <= weight_g;
                        stable_cnt_q <= 8'd1;
                        busy_q       <= 1'b1;
                        state_q      <= StSettle;
                    end
                end
                StSettle: begin
                    if (weight_low) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (weight_valid) begin
                        if (!weight_near) begin
                            ref_q        <= weight_g;
                            stable_cnt_q <= 8'd1;
                        end else if (stable_cnt_q + 8'd1 == 8'(STABLE_SAMPLES)) begin
                            item_weight_q <= ref_q;
                            cam_trigger_q <= 1'b1;
                            timer_q       <= '0;
                            retry_q       <= '0;
                            state_q       <= StScan;
                        end else begin
                            stable_cnt_q <= stable_cnt_q + 8'd1;
                        end
                    end
                end
                StScan: begin
                    if (weight_low) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (cam_valid && id_ok) begin
                        item_id_q <= cam_product;
                        div_q     <= 32'(item_weight_q) * 32'(price) + 32'd500;
                        rem_q     <= '0;
                        iter_q    <= '0;
                        state_q   <= StCalc;
                    end else if (cam_valid || timeout) begin
                        if (retry_q < 8'(SCAN_RETRIES)) begin
                            retry_q       <= retry_q + 8'd1;
                            timer_q       <= '0;
                            cam_trigger_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= StError;
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                StCalc: begin
                    if (iter_q == 6'd32) begin
                        item_cost_q <= div_q[23:0];
                        out_valid_q <= 1'b1;
                        state_q     <= StPresent;
                    end else begin
                        div_q  <= {div_q[30:0], quo_bit};
                        rem_q  <= rem_d;
                        iter_q <= iter_q + 6'd1;
                    end
                end
                StPresent: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StWaitClear;
                    end
                end
                StWaitClear: begin
                    if (weight_low) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StError: begin
                    if (weight_low) begin
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cam_trigger = cam_trigger_q;
    assign out_valid   = out_valid_q;
    assign item_id     = item_id_q;
    assign item_weight = item_weight_q;
    assign item_cost   = item_cost_q;
    assign busy        = busy_q;
    assign err         = err_q;

`ifdef TOTAL_CNT_EN
    logic [31:0] total_q;
    logic [32:0] total_sum;

    assign total_sum = {1'b0, total_q} + 33'(item_cost_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_q <= '0;
        end else if (total_clr) begin
            total_q <= '0;
        end else if (out_valid_q && out_ready) begin
            total_q <= total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
        end
    end

    assign total_cents = total_q;
`endif

endmodule

// File: tb/tb_weigh_scan_controller.sv
// Directed self-checking bench for weigh_scan_controller; covers TOTAL_CNT_EN when defined.
module tb_weigh_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] weight_g = '0;
    logic        weight_valid = 1'b0;
    logic        cam_trigger;
    logic [2:0]  cam_product = '0;
    logic        cam_valid = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  item_id;
    logic [15:0] item_weight;
    logic [23:0] item_cost;
    logic        busy;
    logic        err;
`ifdef TOTAL_CNT_EN
    logic        total_clr = 1'b0;
    logic [31:0] total_cents;
`endif

    int nvec  = 0;
    int nfail = 0;

    weigh_scan_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .weight_g     (weight_g),
        .weight_valid (weight_valid),
        .cam_trigger  (cam_trigger),
        .cam_product  (cam_product),
        .cam_valid    (cam_valid),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .item_id      (item_id),
        .item_weight  (item_weight),
        .item_cost    (item_cost),
        .busy         (busy),
        .err          (err)
`ifdef TOTAL_CNT_EN
        ,
        .total_clr    (total_clr),
        .total_cents  (total_cents)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [15:0] w);
        weight_g     = w;
        weight_valid = 1'b1;
        tick();
        weight_valid = 1'b0;
    endtask

    task automatic cam(input logic [2:0] id);
        cam_product = id;
        cam_valid   = 1'b1;
        tick();
        cam_valid   = 1'b0;
    endtask

    int ntrig, t2, t3, terr;

    initial begin
        // Reset
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_cost", item_cost, 0);
        check("rst_trig", cam_trigger, 0);
        rst_n = 1'b1;
        tick();

        // Camera output outside SCAN is ignored
        cam(3'b001);
        check("idle_cam_busy", busy, 0);

        // 1500 g banana: 180 cents, out_valid 33 cycles after CALC entry
        repeat (4) sample(16'd1500);
        check("s1_trig", cam_trigger, 1);
        check("s1_weight", item_weight, 1500);
        check("s1_busy", busy, 1);
        tick();
        check("s1_trig_pulse", cam_trigger, 0);
        cam(3'b001);
        repeat (32) tick();
        check("s1_valid_early", out_valid, 0);
        tick();
        check("s1_valid_33", out_valid, 1);
        check("s1_id", item_id, 3'b001);
        check("s1_cost", item_cost, 180);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("s1_accept", out_valid, 0);
`ifdef TOTAL_CNT_EN
        check("s1_total", total_cents, 180);
`endif
        check("s1_wait_clear_busy", busy, 1);
        sample(16'd0);
        check("s1_idle", busy, 0);

        // 1234 g maracuja: 555 cents, held while out_ready low
        repeat (4) sample(16'd1234);
        cam(3'b010);
        repeat (33) tick();
        check("s2_valid", out_valid, 1);
        check("s2_cost", item_cost, 555);
        repeat (10) tick();
        check("s2_hold_valid", out_valid, 1);
        check("s2_hold_cost", item_cost, 555);
        check("s2_hold_id", item_id, 3'b010);
        check("s2_hold_weight", item_weight, 1234);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("s2_accept", out_valid, 0);
`ifdef TOTAL_CNT_EN
        check("s2_total", total_cents, 735);
        total_clr = 1'b1;
        tick();
        total_clr = 1'b0;
        check("total_clr", total_cents, 0);
`endif
        sample(16'd0);

        // Reference restarts on a 10 g jump; abort on empty pan during SCAN
        sample(16'd1500);
        repeat (3) sample(16'd1510);
        check("s3_not_stable", cam_trigger, 0);
        sample(16'd1510);
        check("s3_trig", cam_trigger, 1);
        check("s3_weight", item_weight, 1510);
        sample(16'd0);
        check("s3_abort_busy", busy, 0);
        check("s3_abort_valid", out_valid, 0);

        // No camera response: three triggers 1000 apart, then error
        repeat (4) sample(16'd800);
        check("s4_trig0", cam_trigger, 1);
        ntrig = 1; t2 = -1; t3 = -1; terr = -1;
        for (int c = 1; c <= 3100; c++) begin
            tick();
            if (cam_trigger) begin
                ntrig++;
                if (ntrig == 2) t2 = c;
                else if (ntrig == 3) t3 = c;
            end
            if (err && terr < 0) terr = c;
        end
        check("s4_ntrig", ntrig, 3);
        check("s4_t2", t2, 1000);
        check("s4_t3", t3, 2000);
        check("s4_err_cycle", terr, 3000);
        check("s4_err_valid", out_valid, 0);
        sample(16'd0);
        check("s4_err_clear", err, 0);
        check("s4_idle", busy, 0);

        // Invalid ID retries once, then tangerina at 700 g: 161 cents
        repeat (4) sample(16'd700);
        tick();
        tick();
        cam(3'b011);
        check("s5_retry_trig", cam_trigger, 1);
        check("s5_no_err", err, 0);
        cam(3'b100);
        repeat (33) tick();
        check("s5_valid", out_valid, 1);
        check("s5_id", item_id, 3'b100);
        check("s5_cost", item_cost, 161);
        check("s5_weight", item_weight, 700);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        sample(16'd0);

        // Reset during CALC
        repeat (4) sample(16'd900);
        cam(3'b001);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_calc_busy", busy, 0);
        check("rst_calc_cost", item_cost, 0);
        repeat (40) tick();
        check("rst_calc_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
